fifo_switch_arbiter: RTL and testbench

Arbiter and sequencer between the four input FIFOs and the four output FIFOs of the 4x4 FIFO switch. Each cycle it picks one non-empty input FIFO, pops its head word, and pushes that word into the output FIFO selected by the word's two destination bits. All transfers stall while any output FIFO reports almost-full. It runs only while the main state machine holds it enabled, after thresholds are configured.

---
 rtl/fifo_switch_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_switch_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_switch_arbiter.sv
// fifo_switch_arbiter
// Moves one word per cycle from a non-empty input FIFO (0..3) to the output
// FIFO (4..7) named by the word's two top bits. Any almost-full output stalls
// every transfer. Pops are combinational; push/data/grant are registered.
//
// Build option: define ROUND_ROBIN_EN for rotating priority (pointer register,
// reset 0, advanced to winner+1 after each grant). Without it priority is
// fixed 0 > 1 > 2 > 3 and no pointer register exists.
module fifo_switch_arbiter #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        empty_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        almost_full_out,
  output logic [3:0]        pop_in,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant_idx,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] XFER  = 2'b01;
  localparam logic [1:0] STALL = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [3:0]        push_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        grant_q;

  logic              stall;
  logic [3:0]        req;
  logic              any_req;
  logic [DATA_W-1:0] din [4];
  logic [1:0]        base;
  logic [1:0]        idx;
  logic              win_valid;
  logic [1:0]        win_idx;
  logic              grant;
  logic [DATA_W-1:0] win_data;
  logic [3:0]        dest_onehot;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  // Stall is global: one almost-full output blocks every input (head-of-line).
  assign stall   = |almost_full_out;
  assign req     = ~empty_in & {4{enable}};
  assign any_req = |req;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign base = ptr_q;

  // Pointer moves past the winner only when a word actually leaves.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = win_idx + 2'd1;
  end

  // Rotating-priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign base = 2'd0;
`endif

  // Priority search starting at base, wrapping modulo 4.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    win_valid = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + i[1:0];
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Grant comes straight from current req/stall so the first pop is same-cycle.
  assign grant       = win_valid & ~stall & ~reset;
  assign pop_in      = grant ? (4'b0001 << win_idx) : 4'b0000;
  assign win_data    = din[win_idx];
  assign dest_onehot = 4'b0001 << win_data[DATA_W-1 -: 2];

  // Next state from the current-cycle request and stall conditions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, XFER: begin
        if (!any_req)    state_d = IDLE;
        else if (!stall) state_d = XFER;
        else             state_d = STALL;
      end
      STALL: begin
        if (!stall) state_d = any_req ? XFER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered push path: a word popped this cycle is pushed on the next edge,
  // even if enable drops or reset rises in that next cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      push_q  <= 4'b0000;
      data_q  <= '0;
      grant_q <= 2'd0;
    end else begin
      state_q <= state_d;
      push_q  <= grant ? dest_onehot : 4'b0000;
      if (grant) begin
        data_q  <= win_data;
        grant_q <= win_idx;
      end
    end
  end

  assign push_out  = push_q;
  assign data_out  = data_q;
  assign grant_idx = grant_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fifo_switch_arbiter.sv
// Directed testbench for fifo_switch_arbiter. Expected pushes are queued when
// the matching pop is observed; a monitor pops and compares each push pulse.
module tb_fifo_switch_arbiter;

  localparam int DATA_W = 10;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] XFER  = 2'b01;
  localparam logic [1:0] STALL = 2'b10;

  typedef struct {
    logic [3:0]        push;
    logic [DATA_W-1:0] data;
    logic [1:0]        grant;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [3:0]        empty_in;
  logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]        almost_full_out;
  logic [3:0]        pop_in;
  logic [3:0]        push_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_idx;
  logic [1:0]        state;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  fifo_switch_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
    .data_in3(data_in3), .almost_full_out(almost_full_out),
    .pop_in(pop_in), .push_out(push_out), .data_out(data_out),
    .grant_idx(grant_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check pop_in at the negedge; queue the push it must cause; return at
  // posedge+1 so the caller can change inputs for the next cycle.
  task automatic cyc(input string name, input logic [3:0] exp_pop,
                     input logic [3:0] exp_push, input logic [DATA_W-1:0] d,
                     input logic [1:0] g);
    exp_t e;
    @(negedge clk);
    check(name, {28'd0, pop_in}, {28'd0, exp_pop});
    if (exp_pop != 4'b0000) begin
      e.push = exp_push; e.data = d; e.grant = g;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every push pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && push_out !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_push", {28'd0, push_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("push_out",  {28'd0, push_out},  {28'd0, e.push});
        check("data_out",  {22'd0, data_out},  {22'd0, e.data});
        check("grant_idx", {30'd0, grant_idx}, {30'd0, e.grant});
      end
    end
  end

  logic [DATA_W-1:0] words [4];

  initial begin
    reset = 1'b1; enable = 1'b1; empty_in = 4'b0000; almost_full_out = 4'b0000;
    data_in0 = 10'h3FF; data_in1 = 10'h3FF; data_in2 = 10'h3FF; data_in3 = 10'h3FF;

    // Reset held two cycles with all inputs non-empty.
    @(posedge clk); @(posedge clk); #1;
    check("rst_pop",   {28'd0, pop_in},    32'd0);
    check("rst_push",  {28'd0, push_out},  32'd0);
    check("rst_data",  {22'd0, data_out},  32'd0);
    check("rst_grant", {30'd0, grant_idx}, 32'd0);
    check("rst_state", {30'd0, state},     {30'd0, IDLE});
    reset = 1'b0; empty_in = 4'b1111;

    // Priority order, one word per input.
    words[0] = 10'h001; words[1] = 10'h101; words[2] = 10'h201; words[3] = 10'h301;
    data_in0 = words[0]; data_in1 = words[1]; data_in2 = words[2]; data_in3 = words[3];
    empty_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cyc("prio_pop", 4'b0001 << i, 4'b0001 << i, words[i], 2'(i));
      if (i == 0) check("prio_state", {30'd0, state}, {30'd0, XFER});
      empty_in[i] = 1'b1;
    end
    cyc("idle_pop", 4'b0000, 4'b0000, '0, 2'd0);
    check("idle_state", {30'd0, state}, {30'd0, IDLE});

    // Global almost-full stall, then resume.
    data_in0 = 10'h155; empty_in = 4'b0000; almost_full_out = 4'b0100;
    cyc("stall_pop", 4'b0000, 4'b0000, '0, 2'd0);
    check("stall_state", {30'd0, state},    {30'd0, STALL});
    check("stall_push",  {28'd0, push_out}, 32'd0);
    almost_full_out = 4'b0000;
    cyc("resume_pop", 4'b0001, 4'b0010, 10'h155, 2'd0);
    check("resume_state", {30'd0, state}, {30'd0, XFER});
    empty_in = 4'b1111;

    // Lowest-priority input alone.
    data_in3 = 10'h3C3; empty_in = 4'b0111;
    cyc("in3_pop", 4'b1000, 4'b1000, 10'h3C3, 2'd3);
    empty_in = 4'b1111;

    // Two inputs bound for the same output serialize, input 0 first.
    data_in0 = 10'h0AA; data_in1 = 10'h0AA; empty_in = 4'b1100;
    cyc("cont_pop0", 4'b0001, 4'b0001, 10'h0AA, 2'd0);
    empty_in = 4'b1101;
    cyc("cont_pop1", 4'b0010, 4'b0001, 10'h0AA, 2'd1);
    empty_in = 4'b1111;

    // enable drops right after a pop: one more push, then IDLE, then resume.
    data_in3 = 10'h1E3; empty_in = 4'b0111;
    cyc("en_pop", 4'b1000, 4'b0010, 10'h1E3, 2'd3);
    enable = 1'b0; data_in3 = 10'h0E7;
    cyc("en_off_pop", 4'b0000, 4'b0000, '0, 2'd0);
    check("en_off_push",  {28'd0, push_out}, 32'd0);
    check("en_off_state", {30'd0, state},    {30'd0, IDLE});
    enable = 1'b1;
    cyc("en_resume_pop", 4'b1000, 4'b0001, 10'h0E7, 2'd3);
    empty_in = 4'b1111;

    // All four inputs continuously non-empty.
    words[0] = 10'h011; words[1] = 10'h122; words[2] = 10'h233; words[3] = 10'h344;
    data_in0 = words[0]; data_in1 = words[1]; data_in2 = words[2]; data_in3 = words[3];
    empty_in = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
`ifdef ROUND_ROBIN_EN
      g = 2'(k % 4);
`else
      g = 2'd0;
`endif
      cyc("rot_pop", 4'b0001 << g, 4'b0001 << g, words[g], g);
    end
    empty_in = 4'b1111;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
